// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard scan controller.
//   - Bus word addresses for the DATA / STATUS / CTRL registers
//   - Scan-code prefix bytes (E0 = extended, F0 = break)
//   - Parser state encoding
//   - Event word layout: [9] brk, [8] ext, [7:0] code
package kbd_pkg;

    localparam logic [1:0] KBD_DATA   = 2'd0;
    localparam logic [1:0] KBD_STATUS = 2'd1;
    localparam logic [1:0] KBD_CTRL   = 2'd2;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_EXT    = 2'd1,
        P_BRK    = 2'd2,
        P_EXTBRK = 2'd3
    } parse_state_t;

    localparam int EV_W   = 10;
    localparam int EV_BRK = 9;
    localparam int EV_EXT = 8;

    // Register bit positions
    localparam int ST_OVF_BIT     = 3;
    localparam int CTRL_IE_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    function automatic logic [EV_W-1:0] make_event(input logic brk, input logic ext,
                                                   input logic [7:0] code);
        logic [EV_W-1:0] ev;
        ev         = '0;
        ev[EV_BRK] = brk;
        ev[EV_EXT] = ext;
        ev[7:0]    = code;
        return ev;
    endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// Single-clock FIFO holding decoded keyboard events.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request / data (ignored when full unless a pop is also taken)
//   pop              read request (ignored when empty); pop_data shows the head entry
//   flush            empties the FIFO; takes priority over push and pop
//   full, empty      status flags
//   count            occupancy 0..DEPTH
module kbd_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Bus-side PS/2 keyboard controller.
// Raw scan bytes arrive with an asynchronous ready_pulse strobe, are synchronised,
// decoded (E0 extended / F0 break prefixes) into 10-bit event words and queued.
// The CPU reads events and status over an STB/ACK slave bus.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   ready_pulse         byte strobe from the PS/2 receiver (asynchronous)
//   Keyboard_Data       raw scan byte, stable while ready_pulse is high
//   STB, WE, ADR, DAT_I bus request: strobe, write enable, word address, write data
//   DAT_O, ACK          registered read data and single-cycle acknowledge
//   irq                 level interrupt: CTRL.ie & FIFO not empty
//   parser_state        current prefix-parser state (debug observation)
// Bus handshake: a request is taken when STB=1, ACK=0 and the previous request has
// been released (STB seen low). ACK rises for exactly one cycle on the following edge,
// with DAT_O loaded on that same edge; each request has exactly one side effect.
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter bit KEEP_BREAK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_pulse,
    input  logic [7:0]  Keyboard_Data,
    input  logic        STB,
    input  logic        WE,
    input  logic [1:0]  ADR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        irq,
    output logic [1:0]  parser_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    // ---------------- strobe synchroniser + rising-edge detect ----------------
    logic [2:0] sync_q;
    logic       byte_stb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], ready_pulse};
    end

    assign byte_stb = sync_q[1] & ~sync_q[2];

    // ---------------- prefix parser ----------------
    parse_state_t    state;
    logic            ev_valid;
    logic [EV_W-1:0] ev_word;
    logic            is_e0, is_f0, cur_brk, cur_ext;
    logic            flush;

    assign is_e0   = (Keyboard_Data == PFX_EXT);
    assign is_f0   = (Keyboard_Data == PFX_BRK);
    assign cur_brk = (state == P_BRK) || (state == P_EXTBRK);
    assign cur_ext = (state == P_EXT) || (state == P_EXTBRK);

    // Prefixes accumulate: E0 adds the extended flag, F0 adds the break flag;
    // any other byte emits the accumulated flags with the code and returns to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= P_IDLE;
            ev_valid <= 1'b0;
            ev_word  <= '0;
        end else begin
            ev_valid <= 1'b0;
            if (flush) begin
                state <= P_IDLE;
            end else if (byte_stb) begin
                if (is_e0) begin
                    state <= cur_brk ? P_EXTBRK : P_EXT;
                end else if (is_f0) begin
                    state <= cur_ext ? P_EXTBRK : P_BRK;
                end else begin
                    state    <= P_IDLE;
                    ev_word  <= make_event(cur_brk, cur_ext, Keyboard_Data);
                    ev_valid <= KEEP_BREAK || !cur_brk;
                end
            end
        end
    end

    assign parser_state = state;

    // ---------------- event FIFO ----------------
    logic [EV_W-1:0] fifo_head;
    logic            full, empty, pop;
    logic [CW-1:0]   count;

    kbd_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (ev_valid),
        .push_data (ev_word),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (fifo_head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // ---------------- bus slave ----------------
    logic        done, access, rd_en, wr_en;
    logic        ie, overflow;
    logic [31:0] rd_data;

    // done blocks a second request until the master drops STB.
    assign access = STB && !ACK && !done;
    assign rd_en  = access && !WE;
    assign wr_en  = access && WE;
    assign pop    = rd_en && (ADR == KBD_DATA) && !empty;
    assign flush  = wr_en && (ADR == KBD_CTRL) && DAT_I[CTRL_FLUSH_BIT];

    always_comb begin
        rd_data = '0;
        case (ADR)
            KBD_DATA:   if (!empty) rd_data = {1'b1, 21'b0, fifo_head};
            KBD_STATUS: rd_data = {16'b0, 8'(count), 4'b0, overflow, 1'b0, full, empty};
            KBD_CTRL:   rd_data = {31'b0, ie};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ACK      <= 1'b0;
            done     <= 1'b0;
            DAT_O    <= '0;
            ie       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ACK <= access;
            if (access)    done <= 1'b1;
            else if (!STB) done <= 1'b0;

            if (rd_en)      DAT_O <= rd_data;
            else if (wr_en) DAT_O <= '0;

            if (wr_en && (ADR == KBD_CTRL)) ie <= DAT_I[CTRL_IE_BIT];

            // Drop only when no slot frees up this cycle; a flush discards the event instead.
            if (ev_valid && full && !pop && !flush)
                overflow <= 1'b1;
            else if (wr_en && (ADR == KBD_STATUS) && DAT_I[ST_OVF_BIT])
                overflow <= 1'b0;
        end
    end

    assign irq = ie & ~empty;

    logic unused_dat_i;
    assign unused_dat_i = ^{DAT_I[31:4], DAT_I[2]};

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: one instance with break events kept, one with them discarded,
// sharing all inputs. Expected bus read data is queued at request time and popped by a
// monitor on every ACK.
module tb_kbd_scan_ctrl;
  import kbd_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ready_pulse;
  logic [7:0]  Keyboard_Data;
  logic        STB, WE;
  logic [1:0]  ADR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O, dat_o1;
  logic        ACK, ack1, irq, irq1;
  logic [1:0]  pstate, pstate1;

  kbd_scan_ctrl #(.DEPTH(DEPTH), .KEEP_BREAK(1'b1)) dut (
    .clk(clk), .reset(reset), .ready_pulse(ready_pulse), .Keyboard_Data(Keyboard_Data),
    .STB(STB), .WE(WE), .ADR(ADR), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .irq(irq),
    .parser_state(pstate)
  );

  kbd_scan_ctrl #(.DEPTH(DEPTH), .KEEP_BREAK(1'b0)) dut_nobrk (
    .clk(clk), .reset(reset), .ready_pulse(ready_pulse), .Keyboard_Data(Keyboard_Data),
    .STB(STB), .WE(WE), .ADR(ADR), .DAT_I(DAT_I), .DAT_O(dat_o1), .ACK(ack1), .irq(irq1),
    .parser_state(pstate1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  logic ack_prev = 1'b0;
  logic ack1_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] mq0[$];
  logic [9:0] mq1[$];
  bit m_ext, m_brk, m_ie, ovf0, ovf1;

  function automatic logic [31:0] status_exp(input int n, input bit ovf);
    logic [31:0] w;
    w       = '0;
    w[15:8] = 8'(n);
    w[3]    = ovf;
    w[1]    = (n == DEPTH);
    w[0]    = (n == 0);
    return w;
  endfunction

  task automatic model_push(input logic [9:0] ev, input bit keep);
    if (mq0.size() < DEPTH) mq0.push_back(ev); else ovf0 = 1'b1;
    if (!keep) begin
      if (mq1.size() < DEPTH) mq1.push_back(ev); else ovf1 = 1'b1;
    end
  endtask

  // Prefixes only set flags; the next non-prefix byte emits them and clears them.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      model_push({m_brk, m_ext, b}, m_brk);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    m_ext = 0; m_brk = 0; m_ie = 0; ovf0 = 0; ovf1 = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {compare, data} for the KEEP_BREAK=1 instance
  logic [32:0] exp1_q[$];  // same for the KEEP_BREAK=0 instance

  always @(negedge clk) begin
    if (ACK) begin
      logic [32:0] e;
      ack_cnt++;
      check("ack_single_cycle", 32'(ack_prev), 32'd0);
      if (exp_q.size() == 0) check("ack_without_request", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        if (e[32]) check("rd_data", DAT_O, e[31:0]);
      end
    end
    if (ack1) begin
      logic [32:0] e;
      if (exp1_q.size() == 0) check("ack_without_request_nobrk", 32'(exp1_q.size()), 32'd1);
      else begin
        e = exp1_q.pop_front();
        if (e[32]) check("rd_data_nobrk", dat_o1, e[31:0]);
      end
    end
    ack_prev  <= ACK;
    ack1_prev <= ack1;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_start(input bit we, input logic [1:0] adr, input logic [31:0] wdat);
    logic [32:0] e0, e1;
    e0 = {1'b0, 32'h0};
    e1 = {1'b0, 32'h0};
    if (!we) begin
      case (adr)
        KBD_DATA: begin
          e0 = {1'b1, 32'h0};
          e1 = {1'b1, 32'h0};
          if (mq0.size() > 0) e0 = {1'b1, 1'b1, 21'b0, mq0.pop_front()};
          if (mq1.size() > 0) e1 = {1'b1, 1'b1, 21'b0, mq1.pop_front()};
        end
        KBD_STATUS: begin
          e0 = {1'b1, status_exp(mq0.size(), ovf0)};
          e1 = {1'b1, status_exp(mq1.size(), ovf1)};
        end
        KBD_CTRL: begin
          e0 = {1'b1, 31'b0, m_ie};
          e1 = e0;
        end
        default: begin
          e0 = {1'b1, 32'h0};
          e1 = e0;
        end
      endcase
    end else begin
      if (adr == KBD_STATUS && wdat[3]) begin ovf0 = 0; ovf1 = 0; end
      if (adr == KBD_CTRL) begin
        m_ie = wdat[0];
        if (wdat[1]) begin mq0.delete(); mq1.delete(); m_ext = 0; m_brk = 0; end
      end
    end
    exp_q.push_back(e0);
    exp1_q.push_back(e1);
    @(posedge clk); #1;
    STB = 1'b1; WE = we; ADR = adr; DAT_I = wdat;
  endtask

  task automatic bus_finish(input int extra);
    int k;
    k = 0;
    while (!ACK && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("ack_seen", 32'(ACK), 32'd1);
    repeat (extra) @(posedge clk);
    #1;
    STB = 1'b0; WE = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus(input bit we, input logic [1:0] adr, input logic [31:0] wdat);
    bus_start(we, adr, wdat);
    bus_finish(0);
  endtask

  task automatic rd(input logic [1:0] adr);
    bus(1'b0, adr, 32'h0);
  endtask

  task automatic byte_rise(input logic [7:0] b);
    @(posedge clk); #1;
    Keyboard_Data = b;
    ready_pulse   = 1'b1;
  endtask

  task automatic byte_fall();
    repeat (3) @(posedge clk);
    #1;
    ready_pulse = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_rise(b);
    byte_fall();
    model_byte(b);
  endtask

  task automatic check_state();
    check("irq", 32'(irq), 32'(m_ie && mq0.size() != 0));
    check("irq_nobrk", 32'(irq1), 32'(m_ie && mq1.size() != 0));
    check("parser_idle", 32'(pstate == P_IDLE), 32'(!m_ext && !m_brk));
  endtask

  task automatic check_reset_outputs();
    check("rst_dat_o", DAT_O, 32'h0);
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_parser", 32'(pstate), 32'(P_IDLE));
    check("rst_dat_o_nobrk", dat_o1, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; STB = 1'b0; WE = 1'b0; ready_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    model_reset();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rand_byte();
    int p;
    logic [7:0] b;
    p = $urandom_range(0, 9);
    if (p == 0) return 8'hE0;
    if (p < 3) return 8'hF0;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
    return b;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a;
    ready_pulse = 0; Keyboard_Data = 0; STB = 0; WE = 0; ADR = 0; DAT_I = 0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;
    @(posedge clk); #1;
    rd(KBD_STATUS);

    // single make code, interrupt enable follows CTRL.ie
    send_byte(8'h1C);
    check_state();
    bus(1'b1, KBD_CTRL, 32'h1);
    check_state();
    rd(KBD_CTRL);
    bus(1'b1, KBD_CTRL, 32'h0);
    check_state();
    bus(1'b1, KBD_CTRL, 32'h1);
    rd(KBD_DATA);
    check_state();
    rd(KBD_STATUS);

    // extended break sequence collapses into one event
    send_byte(8'hE0); check_state();
    send_byte(8'hF0); check_state();
    send_byte(8'h75); check_state();
    rd(KBD_STATUS);
    rd(KBD_DATA);
    rd(KBD_DATA);
    bus(1'b1, KBD_CTRL, 32'h0);

    // overflow: 17 events into 16 slots
    for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
    rd(KBD_STATUS);
    for (int i = 0; i < 16; i++) rd(KBD_DATA);
    rd(KBD_STATUS);
    bus(1'b1, KBD_STATUS, 32'h8);
    rd(KBD_STATUS);

    // push of a new event in the same cycle as a pop from a full FIFO
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    byte_rise(8'h5A);
    repeat (2) @(posedge clk);
    bus_start(1'b0, KBD_DATA, 32'h0);
    model_byte(8'h5A);
    bus_finish(0);
    byte_fall();
    rd(KBD_STATUS);
    for (int i = 0; i < 16; i++) rd(KBD_DATA);
    rd(KBD_STATUS);

    // STB held high for five cycles: one ACK, one side effect
    a = ack_cnt;
    bus_start(1'b0, KBD_DATA, 32'h0);
    bus_finish(4);
    check("hold_empty_one_ack", 32'(ack_cnt - a), 32'd1);
    send_byte(8'h22);
    send_byte(8'h23);
    a = ack_cnt;
    bus_start(1'b0, KBD_DATA, 32'h0);
    bus_finish(4);
    check("hold_full_one_ack", 32'(ack_cnt - a), 32'd1);
    rd(KBD_STATUS);
    rd(KBD_DATA);

    // reset between prefix and code
    send_byte(8'h11);
    send_byte(8'hE0);
    check_state();
    do_reset();
    rd(KBD_STATUS);
    send_byte(8'h75);
    rd(KBD_DATA);

    // break event: kept by one instance, discarded by the other
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_state();
    rd(KBD_STATUS);
    rd(KBD_DATA);

    // flush with entries and a pending prefix
    send_byte(8'h44);
    send_byte(8'hE0);
    bus(1'b1, KBD_CTRL, 32'h3);
    check_state();
    rd(KBD_STATUS);
    rd(3);
    bus(1'b1, 3, 32'hFFFF_FFFF);
    rd(KBD_CTRL);

    // randomized mix
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      send_byte(rand_byte());
      else if (r < 83) rd(KBD_DATA);
      else if (r < 89) rd(KBD_STATUS);
      else if (r < 93) bus(1'b1, KBD_CTRL, {30'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))});
      else if (r < 96) bus(1'b1, KBD_STATUS, 32'h8);
      else if (r < 98) rd(KBD_CTRL);
      else             bus(1'($urandom_range(0, 1)), 3, $urandom);
      check_state();
    end
    rd(KBD_STATUS);

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp1_q_drained", 32'(exp1_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
